// File: rtl/fb_txsched.sv
// fb_txsched: frame transmit scheduler. Turns one-cycle state pulses into MAC
// transmit requests, waits for the matching returned frame, retransmits on
// timeout and raises a sticky error on timeout exhaustion or request overrun.
// Optional build macro: FB_TXSCHED_STATS_EN adds the RetryTotal counter output.
module fb_txsched #(
    parameter int TIMEOUT   = 1000,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_top,
    input  logic        rst,
    input  logic        StateNumb,
    input  logic        StateDist,
    input  logic        StateDelay,
    input  logic        StateDelayDist,
    input  logic        StateData,
    input  logic        TxAck,
    input  logic        TxDone,
    input  logic        RxFrameValid,
    input  logic [2:0]  RxFrameType,
    input  logic        ErrClr,
    output logic        TxStartFrm,
    output logic [2:0]  TxFrameType,
    output logic        NumbFrameReturned,
    output logic        DistFrameReturned,
    output logic        DelayFrameReturned,
    output logic        DelayDistFrameReturned,
    output logic        SchedBusy,
    output logic        SchedErr,
    output logic [1:0]  ErrCode
`ifdef FB_TXSCHED_STATS_EN
    ,
    output logic [15:0] RetryTotal
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        TXWAIT = 3'd2,
        RXWAIT = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [2:0]  T_DATA     = 3'd4;
    localparam logic [1:0]  CODE_NONE  = 2'd0;
    localparam logic [1:0]  CODE_TMO   = 2'd1;
    localparam logic [1:0]  CODE_OVR   = 2'd2;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRY);

    state_t      state_reg, state_next;
    logic [2:0]  type_reg, type_next;
    logic [2:0]  retry_reg, retry_next;
    logic [15:0] timer_reg, timer_next;
    logic        tx_start_reg, tx_start_next;
    logic [3:0]  ret_reg, ret_next;
    logic        busy_reg, busy_next;
    logic        err_reg, err_next;
    logic [1:0]  code_reg, code_next;
    logic        retry_inc;

    logic [4:0]  pulses;
    logic        any_pulse;
    logic [2:0]  pulse_type;
    logic        rx_match;
    logic [3:0]  ret_sel;

    // Pulse vector indexed by frame type code.
    assign pulses    = {StateData, StateDelayDist, StateDelay, StateDist, StateNumb};
    assign any_pulse = |pulses;
    assign rx_match  = RxFrameValid && (RxFrameType == type_reg);

    // One-hot select of the return output belonging to the latched type.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ret_sel
            assign ret_sel[gi] = (type_reg == 3'(gi));
        end
    endgenerate

    // Lowest type code wins when several state pulses coincide.
    always_comb begin
        pulse_type = T_DATA;
        for (int i = 4; i >= 0; i--) begin
            if (pulses[i]) begin
                pulse_type = 3'(i);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next    = state_reg;
        type_next     = type_reg;
        retry_next    = retry_reg;
        timer_next    = timer_reg;
        tx_start_next = tx_start_reg;
        ret_next      = 4'b0000;
        err_next      = err_reg;
        code_next     = code_reg;
        retry_inc     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_pulse) begin
                    type_next     = pulse_type;
                    retry_next    = 3'd0;
                    tx_start_next = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (TxAck) begin
                    tx_start_next = 1'b0;
                    state_next    = TXWAIT;
                end
            end
            TXWAIT: begin
                if (TxDone) begin
                    if (type_reg == T_DATA) begin
                        state_next = IDLE;
                    end else begin
                        timer_next = 16'd0;
                        state_next = RXWAIT;
                    end
                end
            end
            RXWAIT: begin
                timer_next = timer_reg + 16'd1;
                if (rx_match) begin
                    // A match wins over a timeout in the same cycle.
                    ret_next   = ret_sel;
                    state_next = IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    if (retry_reg < RETRY_MAX) begin
                        retry_next    = retry_reg + 3'd1;
                        retry_inc     = 1'b1;
                        tx_start_next = 1'b1;
                        state_next    = ISSUE;
                    end else begin
                        err_next   = 1'b1;
                        code_next  = CODE_TMO;
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                if (ErrClr) begin
                    err_next   = 1'b0;
                    code_next  = CODE_NONE;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new request while a frame is in flight aborts it as an overrun.
        if ((state_reg == ISSUE || state_reg == TXWAIT || state_reg == RXWAIT) && any_pulse) begin
            tx_start_next = 1'b0;
            ret_next      = 4'b0000;
            retry_inc     = 1'b0;
            err_next      = 1'b1;
            code_next     = CODE_OVR;
            state_next    = ERROR;
        end

        busy_next = (state_next == ISSUE) || (state_next == TXWAIT) || (state_next == RXWAIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_top) begin
        if (rst) begin
            state_reg    <= IDLE;
            type_reg     <= 3'd0;
            retry_reg    <= 3'd0;
            timer_reg    <= 16'd0;
            tx_start_reg <= 1'b0;
            ret_reg      <= 4'b0000;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            code_reg     <= CODE_NONE;
        end else begin
            state_reg    <= state_next;
            type_reg     <= type_next;
            retry_reg    <= retry_next;
            timer_reg    <= timer_next;
            tx_start_reg <= tx_start_next;
            ret_reg      <= ret_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            code_reg     <= code_next;
        end
    end

    assign TxStartFrm             = tx_start_reg;
    assign TxFrameType            = type_reg;
    assign NumbFrameReturned      = ret_reg[0];
    assign DistFrameReturned      = ret_reg[1];
    assign DelayFrameReturned     = ret_reg[2];
    assign DelayDistFrameReturned = ret_reg[3];
    assign SchedBusy              = busy_reg;
    assign SchedErr               = err_reg;
    assign ErrCode                = code_reg;

`ifdef FB_TXSCHED_STATS_EN
    logic [15:0] retry_total_reg;

    // Saturating count of retransmissions; only rst clears it.
    always_ff @(posedge clk_top) begin
        if (rst) begin
            retry_total_reg <= 16'd0;
        end else if (retry_inc && (retry_total_reg != 16'hFFFF)) begin
            retry_total_reg <= retry_total_reg + 16'd1;
        end
    end

    assign RetryTotal = retry_total_reg;
`endif

endmodule
